// File: rtl/execute_stage_mc_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the multi-cycle execute stage.
// master drives the ID/EX side and consumes EX/MEM; slave is the execute stage.
interface execute_stage_mc_if #(
   parameter int WIDTH = 32,
   parameter int RA_W  = 5
);
   logic             id_ex_valid;
   logic             mem_to_reg_wr;
   logic             reg_wr_en;
   logic             mem_wr_en;
   logic             alu_src_sel;
   logic [2:0]       alu_ctrl;
   logic [1:0]       forwardA_ex;
   logic [1:0]       forwardB_ex;
   logic [RA_W-1:0]  id_ex_rs;
   logic [RA_W-1:0]  id_ex_rt;
   logic [RA_W-1:0]  reg_wr_addr;
   logic [WIDTH-1:0] reg_data1;
   logic [WIDTH-1:0] reg_data2;
   logic [WIDTH-1:0] sign_imm_ext;
   logic [WIDTH-1:0] wb_reg_wr_data;
   logic             mem_stall;
   logic             ex_flush;

   logic             ex_stall;
   logic [RA_W-1:0]  ex_rs;
   logic [RA_W-1:0]  ex_rt;
   logic [RA_W-1:0]  ex_reg_wr_addr;
   logic             ex_reg_wr_en;
   logic             ex_mem_to_reg_wr;
   logic             ex_mem_valid;
   logic             ex_mem_reg_wr_en;
   logic             ex_mem_mem_wr_en;
   logic             ex_mem_mem_to_reg_wr;
   logic [RA_W-1:0]  ex_mem_reg_wr_addr;
   logic [WIDTH-1:0] ex_mem_alu_result;
   logic [WIDTH-1:0] ex_mem_mem_wr_data;

   modport master (
      output id_ex_valid, mem_to_reg_wr, reg_wr_en, mem_wr_en, alu_src_sel, alu_ctrl,
             forwardA_ex, forwardB_ex, id_ex_rs, id_ex_rt, reg_wr_addr,
             reg_data1, reg_data2, sign_imm_ext, wb_reg_wr_data, mem_stall, ex_flush,
      input  ex_stall, ex_rs, ex_rt, ex_reg_wr_addr, ex_reg_wr_en, ex_mem_to_reg_wr,
             ex_mem_valid, ex_mem_reg_wr_en, ex_mem_mem_wr_en, ex_mem_mem_to_reg_wr,
             ex_mem_reg_wr_addr, ex_mem_alu_result, ex_mem_mem_wr_data
   );

   modport slave (
      input  id_ex_valid, mem_to_reg_wr, reg_wr_en, mem_wr_en, alu_src_sel, alu_ctrl,
             forwardA_ex, forwardB_ex, id_ex_rs, id_ex_rt, reg_wr_addr,
             reg_data1, reg_data2, sign_imm_ext, wb_reg_wr_data, mem_stall, ex_flush,
      output ex_stall, ex_rs, ex_rt, ex_reg_wr_addr, ex_reg_wr_en, ex_mem_to_reg_wr,
             ex_mem_valid, ex_mem_reg_wr_en, ex_mem_mem_wr_en, ex_mem_mem_to_reg_wr,
             ex_mem_reg_wr_addr, ex_mem_alu_result, ex_mem_mem_wr_data
   );
endinterface

// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative shift-add
// multiplier and the EX/MEM pipeline register with stall/flush handling.
module execute_stage_mc #(
   parameter int WIDTH     = 32,
   parameter int RA_W      = 5,
   parameter int MUL_CNT_W = $clog2(WIDTH) + 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   execute_stage_mc_if.slave ex_if
);
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;
   localparam logic [MUL_CNT_W-1:0] CNT_ONE  = MUL_CNT_W'(1);
   localparam logic [MUL_CNT_W-1:0] LAST_CNT = MUL_CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_e;

   mul_state_e           state_q;
   logic [WIDTH-1:0]     mcand_q, mplier_q, acc_q;
   logic [MUL_CNT_W-1:0] cnt_q;

   logic             valid_q, valid_d;
   logic             rwe_q, rwe_d;
   logic             mwe_q, mwe_d;
   logic             m2r_q, m2r_d;
   logic [RA_W-1:0]  addr_q, addr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;

   logic [WIDTH-1:0] op_a, st_data, op_b, alu_res;
   logic             is_mul, mul_issue;

   always_comb begin
      case (ex_if.forwardA_ex)
         2'b01:   op_a = ex_if.wb_reg_wr_data;
         2'b10:   op_a = res_q;
         default: op_a = ex_if.reg_data1;
      endcase
      case (ex_if.forwardB_ex)
         2'b01:   st_data = ex_if.wb_reg_wr_data;
         2'b10:   st_data = res_q;
         default: st_data = ex_if.reg_data2;
      endcase
      op_b = ex_if.alu_src_sel ? ex_if.sign_imm_ext : st_data;
   end

   // MUL yields 0 here; its product comes from the accumulator in S_DONE.
   always_comb begin
      alu_res = '0;
      case (ex_if.alu_ctrl)
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         default: alu_res = '0;
      endcase
   end

   assign is_mul    = (ex_if.alu_ctrl == OP_MUL);
   assign mul_issue = (state_q == S_IDLE) && ex_if.id_ex_valid && is_mul &&
                      !ex_if.ex_flush && !ex_if.mem_stall;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (ex_if.ex_flush) begin
         state_q <= S_IDLE;
      end else if (!ex_if.mem_stall) begin
         case (state_q)
            S_IDLE: if (mul_issue) begin
               mcand_q  <= op_a;
               mplier_q <= op_b;
               acc_q    <= '0;
               cnt_q    <= '0;
               state_q  <= S_BUSY;
            end
            S_BUSY: begin
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CNT_ONE;
               // cnt counts iterations already done, so this is the WIDTH-th one
               if (cnt_q == LAST_CNT) state_q <= S_DONE;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ex_if.ex_stall = mul_issue || (state_q == S_BUSY) ||
                           ((state_q == S_DONE) && ex_if.mem_stall) ||
                           (ex_if.mem_stall && ex_if.id_ex_valid);

   always_comb begin
      valid_d = valid_q;
      rwe_d   = rwe_q;
      mwe_d   = mwe_q;
      m2r_d   = m2r_q;
      addr_d  = addr_q;
      res_d   = res_q;
      wdata_d = wdata_q;
      if (ex_if.ex_flush ||
          (!ex_if.mem_stall && ((state_q == S_BUSY) || ((state_q == S_IDLE) && is_mul)))) begin
         valid_d = 1'b0;
         rwe_d   = 1'b0;
         mwe_d   = 1'b0;
         m2r_d   = 1'b0;
         addr_d  = '0;
         res_d   = '0;
         wdata_d = '0;
      end else if (!ex_if.mem_stall) begin
         valid_d = ex_if.id_ex_valid;
         rwe_d   = ex_if.reg_wr_en & ex_if.id_ex_valid;
         mwe_d   = ex_if.mem_wr_en & ex_if.id_ex_valid;
         m2r_d   = ex_if.mem_to_reg_wr & ex_if.id_ex_valid;
         addr_d  = ex_if.reg_wr_addr;
         res_d   = (state_q == S_DONE) ? acc_q : alu_res;
         wdata_d = st_data;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         rwe_q   <= 1'b0;
         mwe_q   <= 1'b0;
         m2r_q   <= 1'b0;
         addr_q  <= '0;
         res_q   <= '0;
         wdata_q <= '0;
      end else begin
         valid_q <= valid_d;
         rwe_q   <= rwe_d;
         mwe_q   <= mwe_d;
         m2r_q   <= m2r_d;
         addr_q  <= addr_d;
         res_q   <= res_d;
         wdata_q <= wdata_d;
      end
   end

   assign ex_if.ex_rs                = ex_if.id_ex_rs;
   assign ex_if.ex_rt                = ex_if.id_ex_rt;
   assign ex_if.ex_reg_wr_addr       = ex_if.reg_wr_addr;
   assign ex_if.ex_reg_wr_en         = ex_if.reg_wr_en;
   assign ex_if.ex_mem_to_reg_wr     = ex_if.mem_to_reg_wr;
   assign ex_if.ex_mem_valid         = valid_q;
   assign ex_if.ex_mem_reg_wr_en     = rwe_q;
   assign ex_if.ex_mem_mem_wr_en     = mwe_q;
   assign ex_if.ex_mem_mem_to_reg_wr = m2r_q;
   assign ex_if.ex_mem_reg_wr_addr   = addr_q;
   assign ex_if.ex_mem_alu_result    = res_q;
   assign ex_if.ex_mem_mem_wr_data   = wdata_q;
endmodule

// File: tb/tb_execute_stage_mc.sv
// Randomized bench for execute_stage_mc: a cycle-level reference (full product
// computed at issue, multiply modelled as a countdown) plus directed literal checks.
module tb_execute_stage_mc;
   localparam int W  = 32;
   localparam int RA = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   execute_stage_mc_if #(.WIDTH(W), .RA_W(RA)) bus ();
   execute_stage_mc #(.WIDTH(W), .RA_W(RA)) dut (.clk_i(clk), .reset_i(reset), .ex_if(bus.slave));

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   // Reference state: m_rem = -1 idle, >0 busy cycles left, 0 product ready.
   int          m_rem = -1;
   logic [W-1:0] m_prod = '0, m_res = '0, m_wdata = '0;
   logic         m_v = 0, m_rwe = 0, m_mwe = 0, m_m2r = 0, m_hold = 0;
   logic [RA-1:0] m_addr = '0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [W-1:0] fwd(input logic [1:0] sel, input logic [W-1:0] rd);
      if (sel == 2'b01) return bus.wb_reg_wr_data;
      if (sel == 2'b10) return m_res;
      return rd;
   endfunction

   function automatic logic [W-1:0] alu_f(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      case (c)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a + b;
         3'd6: return a - b;
         3'd7: return (int'(a) < int'(b)) ? W'(1) : W'(0);
         default: return '0;
      endcase
   endfunction

   function automatic logic [W-1:0] mul_lo(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return p[W-1:0];
   endfunction

   function automatic logic exp_stall_f();
      return (m_rem == -1 && bus.id_ex_valid && bus.alu_ctrl == 3'd3 && !bus.ex_flush && !bus.mem_stall)
             || (m_rem > 0) || (m_rem == 0 && bus.mem_stall) || (bus.mem_stall && bus.id_ex_valid);
   endfunction

   task automatic m_bubble();
      m_v = 0; m_rwe = 0; m_mwe = 0; m_m2r = 0; m_addr = '0; m_res = '0; m_wdata = '0;
   endtask

   task automatic m_load(input logic [W-1:0] r, input logic [W-1:0] sd);
      m_v   = bus.id_ex_valid;
      m_rwe = bus.reg_wr_en & bus.id_ex_valid;
      m_mwe = bus.mem_wr_en & bus.id_ex_valid;
      m_m2r = bus.mem_to_reg_wr & bus.id_ex_valid;
      m_addr = bus.reg_wr_addr;
      m_res = r;
      m_wdata = sd;
   endtask

   always @(posedge clk or posedge reset) begin
      logic [W-1:0] a, sd, b;
      if (reset) begin
         m_rem = -1; m_prod = '0; m_hold = 0;
         m_bubble();
      end else begin
         a  = fwd(bus.forwardA_ex, bus.reg_data1);
         sd = fwd(bus.forwardB_ex, bus.reg_data2);
         b  = bus.alu_src_sel ? bus.sign_imm_ext : sd;
         m_hold = exp_stall_f() && !bus.ex_flush;
         if (bus.ex_flush) begin
            m_bubble(); m_rem = -1;
         end else if (bus.mem_stall) begin
            // everything frozen
         end else if (m_rem == -1) begin
            if (bus.alu_ctrl == 3'd3) begin
               m_bubble();
               if (bus.id_ex_valid) begin m_prod = mul_lo(a, b); m_rem = W; end
            end else m_load(alu_f(bus.alu_ctrl, a, b), sd);
         end else if (m_rem > 0) begin
            m_bubble(); m_rem--;
         end else begin
            m_load(m_prod, sd); m_rem = -1;
         end
      end
   end

   always @(negedge clk) if (chk_en) begin
      chk("ctl", {bus.ex_mem_valid, bus.ex_mem_reg_wr_en, bus.ex_mem_mem_wr_en,
                  bus.ex_mem_mem_to_reg_wr, bus.ex_mem_reg_wr_addr},
                 {m_v, m_rwe, m_mwe, m_m2r, m_addr});
      chk("data", {bus.ex_mem_alu_result, bus.ex_mem_mem_wr_data}, {m_res, m_wdata});
      chk("stall", bus.ex_stall, exp_stall_f());
      chk("pass", {bus.ex_rs, bus.ex_rt, bus.ex_reg_wr_addr, bus.ex_reg_wr_en, bus.ex_mem_to_reg_wr},
                  {bus.id_ex_rs, bus.id_ex_rt, bus.reg_wr_addr, bus.reg_wr_en, bus.mem_to_reg_wr});
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic set_instr(input logic v, input logic [2:0] c, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [W-1:0] r1, input logic [W-1:0] r2, input logic [W-1:0] imm,
                            input logic src, input logic rwe, input logic mwe, input logic m2r);
      bus.id_ex_valid = v; bus.alu_ctrl = c; bus.forwardA_ex = fa; bus.forwardB_ex = fb;
      bus.reg_data1 = r1; bus.reg_data2 = r2; bus.sign_imm_ext = imm; bus.alu_src_sel = src;
      bus.reg_wr_en = rwe; bus.mem_wr_en = mwe; bus.mem_to_reg_wr = m2r;
      bus.id_ex_rs = RA'($urandom); bus.id_ex_rt = RA'($urandom); bus.reg_wr_addr = RA'($urandom);
   endtask

   function automatic logic [W-1:0] rnd();
      case ($urandom % 6)
         0: return '0;
         1: return '1;
         2: return {1'b1, {(W-1){1'b0}}};
         3: return W'($urandom % 16);
         default: return W'($urandom);
      endcase
   endfunction

   // Holds the MUL in ID/EX until ex_stall drops; returns stall-cycle count and
   // how many stall cycles showed a register write on EX/MEM.
   task automatic run_mul(input int s0, input int sl, output int n, output int bad);
      n = 0; bad = 0;
      for (int k = 0; k < 200; k++) begin
         bus.mem_stall = (k >= s0) && (k < s0 + sl);
         #1;
         if (!bus.ex_stall) break;
         n++;
         step();
         if (bus.ex_mem_reg_wr_en) bad++;
      end
      bus.mem_stall = 1'b0;
   endtask

   initial begin
      int n, bad;
      reset = 1'b1;
      bus.mem_stall = 0; bus.ex_flush = 0; bus.wb_reg_wr_data = '0;
      set_instr(0, 3'd0, 0, 0, '0, '0, '0, 0, 0, 0, 0);
      repeat (2) step();
      chk("reset_state", {bus.ex_mem_valid, bus.ex_mem_reg_wr_en, bus.ex_mem_alu_result,
                          bus.ex_mem_mem_wr_data, bus.ex_stall}, '0);
      reset = 1'b0;
      chk_en = 1'b1;

      set_instr(1, 3'd2, 0, 0, 32'h2, 32'h3, '0, 0, 1, 0, 0); step();
      chk("add_seed", bus.ex_mem_alu_result, 32'h5);
      set_instr(1, 3'd2, 2'b10, 0, 32'hDEAD, 32'h3, '0, 0, 1, 0, 0); step();
      chk("add_fwd_mem", {bus.ex_mem_valid, bus.ex_mem_alu_result}, {1'b1, 32'h8});
      set_instr(1, 3'd7, 0, 0, 32'hFFFFFFFF, 32'h1, '0, 0, 1, 0, 0); step();
      chk("slt_neg", bus.ex_mem_alu_result, 32'h1);
      set_instr(1, 3'd6, 0, 0, 32'h0, 32'h1, '0, 0, 1, 0, 0); step();
      chk("sub_wrap", bus.ex_mem_alu_result, 32'hFFFFFFFF);

      set_instr(1, 3'd3, 0, 0, 32'h1234, 32'h10, '0, 0, 1, 0, 0);
      run_mul(0, 0, n, bad);
      chk("mul_stall_cycles", n, 33);
      chk("mul_bubbles", bad, 0);
      step();
      chk("mul_result", {bus.ex_mem_reg_wr_en, bus.ex_mem_alu_result}, {1'b1, 32'h12340});

      set_instr(1, 3'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, 0, 1, 0, 0);
      run_mul(6, 5, n, bad);
      chk("mul_memstall_cycles", n, 38);
      step();
      chk("mul_memstall_result", bus.ex_mem_alu_result, 32'h1);

      set_instr(1, 3'd3, 0, 0, 32'hABC, 32'h7, '0, 0, 1, 0, 0);
      repeat (11) step();
      bus.ex_flush = 1'b1; step(); bus.ex_flush = 1'b0;
      set_instr(0, 3'd2, 0, 0, '0, '0, '0, 0, 1, 0, 0);
      #1;
      chk("flush_mid_mul", {bus.ex_stall, bus.ex_mem_valid, bus.ex_mem_reg_wr_en}, 3'b000);
      step();

      set_instr(1, 3'd3, 0, 0, 32'h55, 32'h3, '0, 0, 1, 0, 0);
      repeat (6) step();
      reset = 1'b1; bus.id_ex_valid = 1'b0;
      #1;
      chk("async_reset", {bus.ex_stall, bus.ex_mem_valid, bus.ex_mem_reg_wr_en,
                          bus.ex_mem_alu_result, bus.ex_mem_mem_wr_data}, '0);
      step(); reset = 1'b0;
      set_instr(1, 3'd2, 0, 0, 32'h7, 32'h9, '0, 0, 1, 0, 0); step();
      chk("add_after_reset", {bus.ex_mem_valid, bus.ex_mem_alu_result}, {1'b1, 32'h10});

      for (int i = 0; i < 3000; i++) begin
         if (!m_hold)
            set_instr(($urandom % 8) != 0, 3'($urandom), 2'($urandom), 2'($urandom), rnd(), rnd(), rnd(),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         else if (m_rem > 0) begin
            bus.forwardA_ex = 2'($urandom); bus.forwardB_ex = 2'($urandom);
            bus.reg_data1 = rnd(); bus.reg_data2 = rnd(); bus.sign_imm_ext = rnd();
         end
         bus.wb_reg_wr_data = rnd();
         bus.mem_stall = ($urandom % 6) == 0;
         bus.ex_flush  = ($urandom % 50) == 0;
         step();
      end
      bus.mem_stall = 0; bus.ex_flush = 0;
      step();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
